// File: rtl/oram_request_frontend_pkg.sv
// Shared types and defaults for the ORAM request front end.
//   ORAM_D       block-number width
//   ORAM_A       block size in bytes (data width is 8*ORAM_A)
//   oram_req_t   one queued client request
//   fe_state_e   front-end sequencing states
package oram_request_frontend_pkg;

  localparam int ORAM_D      = 6;
  localparam int ORAM_A      = 2;
  localparam int ORAM_DATA_W = 8 * ORAM_A;

  localparam int FE_FIFO_DEPTH_DEF = 4;
  localparam int FE_TIMEOUT_DEF    = 1024;

  typedef struct packed {
    logic                   rw;
    logic [ORAM_D-1:0]      block_number;
    logic [ORAM_DATA_W-1:0] wdata;
  } oram_req_t;

  typedef enum logic [1:0] {
    FE_IDLE,
    FE_ISSUE,
    FE_WAIT,
    FE_RESP
  } fe_state_e;

endpackage

// File: rtl/oram_request_frontend_fifo.sv
// In-order request queue for the ORAM front end.
//   clk, rst    clock, async active-low reset
//   push, din   write one request (accepted when not full, or when popping)
//   pop, dout   dout is the head entry; pop advances it
//   full, empty, count   occupancy status
module oram_req_fifo
  import oram_request_frontend_pkg::*;
#(
  parameter  int DEPTH = FE_FIFO_DEPTH_DEF,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  oram_req_t        din,
  input  logic             pop,
  output oram_req_t        dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  oram_req_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];
  // When full, a simultaneous pop frees the slot the write lands in.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/oram_request_frontend.sv
// Client-facing front end for oram_module: queues requests, issues them one at
// a time, supervises each access with a timeout and returns in-order responses.
//   state    | meaning
//   FE_IDLE  | nothing in flight; waits for a queued request
//   FE_ISSUE | one-cycle oram_input_ready pulse for the loaded request
//   FE_WAIT  | waiting for oram_output_ready or timeout
//   FE_RESP  | response held on rsp_* until rsp_ready
// Ports: clk/rst (async active-low); req_* client request port; rsp_* client
// response port; oram_* link to oram_module; fifo_count, busy status.
module oram_request_frontend
  import oram_request_frontend_pkg::*;
#(
  parameter  int FIFO_DEPTH  = FE_FIFO_DEPTH_DEF,
  parameter  int TIMEOUT_CYC = FE_TIMEOUT_DEF,
  localparam int CNT_W       = $clog2(FIFO_DEPTH + 1),
  localparam int TMR_W       = $clog2(TIMEOUT_CYC)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_rw,
  input  logic [ORAM_D-1:0]      req_block_number,
  input  logic [ORAM_DATA_W-1:0] req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_rw,
  output logic [ORAM_DATA_W-1:0] rsp_rdata,
  output logic                   rsp_timeout,
  output logic [ORAM_D-1:0]      oram_rw_block_number,
  output logic [ORAM_DATA_W-1:0] oram_w_value,
  output logic                   oram_rw_indicator,
  output logic                   oram_input_ready,
  input  logic [ORAM_DATA_W-1:0] oram_r_value,
  input  logic                   oram_output_ready,
  output logic [CNT_W-1:0]       fifo_count,
  output logic                   busy
);

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  fe_state_e        state;
  fe_state_e        state_nx;
  oram_req_t        req_in;
  oram_req_t        head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic             load_head;
  logic [TMR_W-1:0] timer;

  assign req_in    = {req_rw, req_block_number, req_wdata};
  assign req_ready = !fifo_full;

  oram_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req_valid && req_ready),
    .din   (req_in),
    .pop   (fifo_pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FE_IDLE;
    else      state <= state_nx;
  end

  // The in-flight request stays at the FIFO head until its response is
  // captured, so fifo_count includes it.
  always_comb begin
    state_nx  = state;
    load_head = 1'b0;
    fifo_pop  = 1'b0;
    case (state)
      FE_IDLE: begin
        if (!fifo_empty) begin
          load_head = 1'b1;
          state_nx  = FE_ISSUE;
        end
      end
      FE_ISSUE: state_nx = FE_WAIT;
      FE_WAIT: begin
        if (oram_output_ready || (timer == TMR_LAST)) begin
          fifo_pop = 1'b1;
          state_nx = FE_RESP;
        end
      end
      FE_RESP: begin
        if (rsp_ready) begin
          if (!fifo_empty) begin
            load_head = 1'b1;
            state_nx  = FE_ISSUE;
          end else begin
            state_nx  = FE_IDLE;
          end
        end
      end
      default: state_nx = FE_IDLE;
    endcase
  end

  assign oram_input_ready = (state == FE_ISSUE);
  assign rsp_valid        = (state == FE_RESP);
  assign busy             = (state != FE_IDLE) || (fifo_count != '0);

  // Counts WAIT cycles; saturates so a long stall never wraps it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer <= '0;
    end else if (state == FE_ISSUE) begin
      timer <= '0;
    end else if ((state == FE_WAIT) && (timer != TMR_LAST)) begin
      timer <= timer + TMR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      oram_rw_indicator    <= 1'b0;
      oram_rw_block_number <= '0;
      oram_w_value         <= '0;
    end else if (load_head) begin
      oram_rw_indicator    <= head.rw;
      oram_rw_block_number <= head.block_number;
      oram_w_value         <= head.wdata;
    end
  end

  // fifo_pop fires only on leaving WAIT; output_ready low there means timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_rw      <= 1'b0;
      rsp_rdata   <= '0;
      rsp_timeout <= 1'b0;
    end else if (fifo_pop) begin
      rsp_rw      <= oram_rw_indicator;
      rsp_timeout <= !oram_output_ready;
      rsp_rdata   <= (oram_output_ready && !oram_rw_indicator) ? oram_r_value : '0;
    end
  end

endmodule

// File: tb/tb_oram_request_frontend.sv
module tb_oram_request_frontend;
  import oram_request_frontend_pkg::*;

  localparam int DEPTH = 4;
  localparam int TMO   = 16;
  localparam int D     = ORAM_D;
  localparam int DW    = ORAM_DATA_W;
  localparam int NBLK  = 1 << D;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_rw = 1'b0;
  logic [D-1:0]  req_block_number = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic          rsp_rw;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_timeout;
  logic [D-1:0]  oram_rw_block_number;
  logic [DW-1:0] oram_w_value;
  logic          oram_rw_indicator;
  logic          oram_input_ready;
  logic [DW-1:0] oram_r_value = '0;
  logic          oram_output_ready = 1'b0;
  logic [CW-1:0] fifo_count;
  logic          busy;

  oram_request_frontend #(
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .req_valid            (req_valid),
    .req_ready            (req_ready),
    .req_rw               (req_rw),
    .req_block_number     (req_block_number),
    .req_wdata            (req_wdata),
    .rsp_valid            (rsp_valid),
    .rsp_ready            (rsp_ready),
    .rsp_rw               (rsp_rw),
    .rsp_rdata            (rsp_rdata),
    .rsp_timeout          (rsp_timeout),
    .oram_rw_block_number (oram_rw_block_number),
    .oram_w_value         (oram_w_value),
    .oram_rw_indicator    (oram_rw_indicator),
    .oram_input_ready     (oram_input_ready),
    .oram_r_value         (oram_r_value),
    .oram_output_ready    (oram_output_ready),
    .fifo_count           (fifo_count),
    .busy                 (busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic rw; logic [DW-1:0] rdata; logic tmo; } exp_t;
  typedef struct { bit stall; int lat; } plan_t;

  exp_t          exp_q[$];
  plan_t         plan_q[$];
  exp_t          hist[$];
  int            acc_cyc[$];
  int            issue_cyc[$];
  int            rise_cyc[$];
  logic [DW-1:0] mdl_mem [NBLK];
  logic [DW-1:0] oram_mem[NBLK];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int mdl_count, issue_due, exp_rise, n_acc, n_resp, n_issue, stub_cnt;
  bit inflight, resp_held, have_pend;

  logic          pend_rw;
  logic [D-1:0]  pend_blk;
  logic [DW-1:0] pend_wdata;
  bit            pend_stall;
  int            pend_lat;

  logic          cap_rw;
  logic [D-1:0]  cap_blk;
  logic [DW-1:0] cap_w;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h cyc=%0d", nm, act, expv, cyc);
    end
  endtask

  task automatic reset_model();
    exp_q.delete();
    plan_q.delete();
    mdl_count = 0; issue_due = -1; n_acc = 0; n_resp = 0; stub_cnt = -1;
    inflight = 0; resp_held = 0; have_pend = 0;
    oram_output_ready = 1'b0;
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_rw"}, rsp_rw, 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "_rsp_timeout"}, rsp_timeout, 0);
    chk({tag, "_oram_blk"}, oram_rw_block_number, 0);
    chk({tag, "_oram_w"}, oram_w_value, 0);
    chk({tag, "_oram_rw"}, oram_rw_indicator, 0);
    chk({tag, "_oram_ir"}, oram_input_ready, 0);
    chk({tag, "_fifo_count"}, fifo_count, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_req_ready"}, req_ready, 1);
  endtask

  // Compare DUT outputs with the model for the current cycle.
  task automatic check_outputs();
    if (inflight) begin
      chk("oram_blk_stable", oram_rw_block_number, cap_blk);
      chk("oram_w_stable", oram_w_value, cap_w);
      chk("oram_rw_stable", oram_rw_indicator, cap_rw);
    end
    if (inflight && cyc == exp_rise) begin
      inflight = 0;
      resp_held = 1;
      mdl_count--;
      rise_cyc.push_back(cyc);
    end
    chk("rsp_valid", rsp_valid, resp_held);
    if (resp_held) begin
      chk("exp_q_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        chk("rsp_rw", rsp_rw, exp_q[0].rw);
        chk("rsp_rdata", rsp_rdata, exp_q[0].rdata);
        chk("rsp_timeout", rsp_timeout, exp_q[0].tmo);
      end
    end
    chk("oram_input_ready", oram_input_ready, cyc == issue_due);
    if (cyc == issue_due) issue_due = -1;
    chk("fifo_count", fifo_count, mdl_count);
    chk("req_ready", req_ready, mdl_count < DEPTH);
    chk("busy", busy, (mdl_count != 0) || inflight || resp_held);
  endtask

  // Behaves as oram_module: performs the access and raises a sticky output_ready.
  task automatic oram_stub();
    plan_t pl;
    if (oram_input_ready) begin
      n_issue++;
      issue_cyc.push_back(cyc);
      chk("plan_available", plan_q.size() != 0, 1);
      pl = '{0, 1};
      if (plan_q.size() != 0) pl = plan_q.pop_front();
      cap_rw = oram_rw_indicator; cap_blk = oram_rw_block_number; cap_w = oram_w_value;
      inflight = 1;
      if (pl.stall) begin
        oram_output_ready = 1'b0;
        oram_r_value = DW'($urandom) | DW'(1);
        stub_cnt = -1;
        exp_rise = cyc + TMO + 1;
      end else begin
        if (oram_rw_indicator) begin
          oram_mem[oram_rw_block_number] = oram_w_value;
          oram_r_value = DW'($urandom) | DW'(1);
        end else begin
          oram_r_value = oram_mem[oram_rw_block_number];
        end
        stub_cnt = pl.lat;
        oram_output_ready = (pl.lat == 0);
        exp_rise = cyc + ((pl.lat < 1) ? 1 : pl.lat) + 1;
      end
    end else if (stub_cnt > 0) begin
      stub_cnt--;
      if (stub_cnt == 0) oram_output_ready = 1'b1;
    end
  endtask

  // Account for the handshakes that happen at the coming clock edge.
  task automatic commit();
    exp_t e;
    bit push, hs;
    push = have_pend && (mdl_count < DEPTH);
    hs   = resp_held && rsp_ready;
    if (hs) begin
      hist.push_back('{rsp_rw, rsp_rdata, rsp_timeout});
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      resp_held = 0;
      n_resp++;
      if (mdl_count > 0) issue_due = cyc + 1;
      else if (push) issue_due = cyc + 2;
    end else if (push && !inflight && !resp_held && mdl_count == 0 && issue_due < 0) begin
      issue_due = cyc + 2;
    end
    if (push) begin
      e.rw = pend_rw;
      e.tmo = pend_stall;
      if (pend_stall) e.rdata = '0;
      else if (pend_rw) begin
        mdl_mem[pend_blk] = pend_wdata;
        e.rdata = '0;
      end else e.rdata = mdl_mem[pend_blk];
      exp_q.push_back(e);
      plan_q.push_back('{pend_stall, pend_lat});
      mdl_count++;
      n_acc++;
      acc_cyc.push_back(cyc);
      have_pend = 0;
    end
  endtask

  task automatic cycle(input bit rr);
    @(negedge clk);
    cyc++;
    check_outputs();
    oram_stub();
    req_valid = have_pend;
    req_rw = pend_rw;
    req_block_number = pend_blk;
    req_wdata = pend_wdata;
    rsp_ready = rr;
    commit();
  endtask

  task automatic set_pend(input logic rw, input int blk, input logic [DW-1:0] wd,
                          input bit stall, input int lat);
    have_pend = 1; pend_rw = rw; pend_blk = D'(blk); pend_wdata = wd;
    pend_stall = stall; pend_lat = lat;
  endtask

  task automatic accept(input bit rr);
    int k;
    k = 0;
    while (have_pend && k < 60) begin
      cycle(rr);
      k++;
    end
    chk("accept_bound", have_pend, 0);
  endtask

  task automatic drain(input int maxc);
    int k;
    k = 0;
    while (n_resp < n_acc && k < maxc) begin
      cycle(1);
      k++;
    end
    chk("drain_bound", n_resp, n_acc);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int h0, i0, r0, a0, n0, k;
    logic s_rw, s_tmo;
    logic [DW-1:0] s_rd, v;

    for (int i = 0; i < NBLK; i++) begin
      v = DW'($urandom);
      mdl_mem[i] = v;
      oram_mem[i] = v;
    end
    reset_model();
    repeat (2) @(negedge clk);
    chk_reset("init");
    @(negedge clk);
    rst = 1'b1;

    // 1: write then read the same block
    h0 = hist.size();
    set_pend(1, 3, 16'hA5A5, 0, 2); accept(1);
    set_pend(0, 3, 16'h0000, 0, 1); accept(1);
    drain(100);
    chk("t1_nresp", hist.size() - h0, 2);
    if (hist.size() >= h0 + 2) begin
      chk("t1_r1_rw", hist[h0].rw, 1);
      chk("t1_r1_rdata", hist[h0].rdata, 0);
      chk("t1_r2_rw", hist[h0+1].rw, 0);
      chk("t1_r2_rdata", hist[h0+1].rdata, 16'hA5A5);
    end

    // 2: fill the queue with the response side stalled
    a0 = acc_cyc.size();
    set_pend(0, 1, 0, 1, 0); accept(0);
    for (int i = 1; i < 4; i++) begin
      set_pend(0, i + 1, 0, 0, 1); accept(0);
    end
    cycle(0);
    chk("t2_count_full", fifo_count, 4);
    chk("t2_req_ready_low", req_ready, 0);
    set_pend(0, 5, 0, 0, 1); accept(0);
    if (acc_cyc.size() >= a0 + 5)
      chk("t2_fifth_accept_delay", acc_cyc[a0+4] - acc_cyc[a0], TMO + 3);
    drain(400);

    // 3: timeout then the next request issues
    h0 = hist.size(); i0 = issue_cyc.size(); r0 = rise_cyc.size();
    set_pend(0, 7, 0, 1, 0); accept(1);
    set_pend(0, 7, 0, 0, 0); accept(1);
    drain(200);
    if (hist.size() >= h0 + 2 && issue_cyc.size() >= i0 + 2 && rise_cyc.size() >= r0 + 1) begin
      chk("t3_rise_after_issue", rise_cyc[r0] - issue_cyc[i0], TMO + 1);
      chk("t3_timeout", hist[h0].tmo, 1);
      chk("t3_rdata_zero", hist[h0].rdata, 0);
      chk("t3_next_issue", issue_cyc[i0+1] - issue_cyc[i0], TMO + 2);
      chk("t3_next_no_timeout", hist[h0+1].tmo, 0);
    end else begin
      chk("t3_history", hist.size() - h0, 2);
    end

    // 4: back-to-back requests
    n0 = n_issue;
    for (int i = 0; i < 3; i++) begin
      set_pend(logic'(i == 1), 10 + i, DW'($urandom), 0, i); accept(1);
    end
    drain(100);
    chk("t4_issue_pulses", n_issue - n0, 3);

    // 5: response held for 10 cycles with another request queued
    set_pend(0, 2, 0, 0, 1); accept(0);
    set_pend(1, 9, 16'h1234, 0, 0); accept(0);
    k = 0;
    while (!resp_held && k < 30) begin
      cycle(0);
      k++;
    end
    chk("t5_resp_seen", resp_held, 1);
    s_rw = rsp_rw; s_rd = rsp_rdata; s_tmo = rsp_timeout;
    n0 = n_issue;
    repeat (10) cycle(0);
    chk("t5_rw_stable", rsp_rw, s_rw);
    chk("t5_rdata_stable", rsp_rdata, s_rd);
    chk("t5_tmo_stable", rsp_timeout, s_tmo);
    chk("t5_valid_held", rsp_valid, 1);
    chk("t5_no_issue", n_issue - n0, 0);
    drain(100);

    // randomized traffic
    for (int i = 0; i < 700; i++) begin
      if (!have_pend && $urandom_range(0, 9) < 6)
        set_pend(logic'($urandom_range(0, 1)), $urandom_range(0, 7), DW'($urandom),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 4));
      cycle($urandom_range(0, 9) < 7);
    end
    have_pend = 0;
    drain(600);

    // 6: reset during WAIT with two more queued (reads only)
    for (int i = 0; i < 3; i++) begin
      set_pend(0, 20 + i, 0, 1, 0); accept(1);
    end
    repeat (3) cycle(1);
    chk("t6_pre_count", fifo_count, 3);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 chk_reset("t6");
    reset_model();
    @(negedge clk);
    rst = 1'b1;
    repeat (30) cycle(1);
    chk("t6_no_response", n_resp, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
